// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: parks on DEF_MASTER, round-robins simultaneous requests,
// honours locked sequences and SEQ bursts, and preempts an owner after MAX_HOLD transfers.
`timescale 1ns/1ps
module ahb_master_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned DEF_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        M0_HBUSREQ,
    input  logic        M0_HLOCK,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HGRANT,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,

    input  logic        M1_HBUSREQ,
    input  logic        M1_HLOCK,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HGRANT,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic        HMASTER,
    output logic        HMASTLOCK
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_PARK = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [1:0] TR_SEQ = 2'b11;

    localparam logic             DEF_IDX    = 1'(DEF_MASTER);
    localparam logic [1:0]       DEF_GRANT  = DEF_IDX ? 2'b10 : 2'b01;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_MAX   = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       grant;
    logic [1:0]       grant_nxt;
    logic             data_master;
    logic             last_owner;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;

    logic [1:0]       own_trans;
    logic             own_lock;
    logic             owner_idx;
    logic             arb_point;

    // Signals of the current address-phase owner decide whether the bus may change hands.
    assign own_trans = HMASTER ? M1_HTRANS : M0_HTRANS;
    assign own_lock  = HMASTER ? M1_HLOCK  : M0_HLOCK;
    assign arb_point = HREADY && (own_trans != TR_SEQ) && !own_lock && !HMASTLOCK;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_PARK;
        end else if (HREADY) begin
            state <= state_nxt;
        end
    end

    // Next owner: keep a requesting owner unless it has exhausted its hold budget.
    always_comb begin
        state_nxt = state;
        grant_nxt = DEF_GRANT;
        if (arb_point) begin
            case (state)
                ST_OWN0: begin
                    if (!M0_HBUSREQ) begin
                        state_nxt = M1_HBUSREQ ? ST_OWN1 : ST_PARK;
                    end else if (M1_HBUSREQ && (hold_cnt >= HOLD_LIMIT)) begin
                        state_nxt = ST_OWN1;
                    end
                end
                ST_OWN1: begin
                    if (!M1_HBUSREQ) begin
                        state_nxt = M0_HBUSREQ ? ST_OWN0 : ST_PARK;
                    end else if (M0_HBUSREQ && (hold_cnt >= HOLD_LIMIT)) begin
                        state_nxt = ST_OWN0;
                    end
                end
                default: begin
                    if (M0_HBUSREQ && M1_HBUSREQ) begin
                        state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
                    end else if (M0_HBUSREQ) begin
                        state_nxt = ST_OWN0;
                    end else if (M1_HBUSREQ) begin
                        state_nxt = ST_OWN1;
                    end else begin
                        state_nxt = ST_PARK;
                    end
                end
            endcase
        end
        case (state_nxt)
            ST_OWN0: grant_nxt = 2'b01;
            ST_OWN1: grant_nxt = 2'b10;
            default: grant_nxt = DEF_GRANT;
        endcase
    end

    // Only transfers the granted owner itself places on the bus count toward its budget.
    always_comb begin
        owner_idx = (state == ST_OWN1);
        hold_nxt  = hold_cnt;
        if ((state_nxt != state) || (state_nxt == ST_PARK)) begin
            hold_nxt = '0;
        end else if ((HMASTER == owner_idx) && own_trans[1] && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant       <= DEF_GRANT;
            HMASTER     <= DEF_IDX;
            HMASTLOCK   <= 1'b0;
            data_master <= DEF_IDX;
            hold_cnt    <= '0;
            last_owner  <= ~DEF_IDX;
        end else if (HREADY) begin
            grant       <= grant_nxt;
            HMASTER     <= grant[1];
            HMASTLOCK   <= grant[1] ? M1_HLOCK : M0_HLOCK;
            data_master <= HMASTER;
            hold_cnt    <= hold_nxt;
            if (state_nxt != ST_PARK) begin
                last_owner <= (state_nxt == ST_OWN1);
            end
        end
    end

    assign M0_HGRANT = grant[0];
    assign M1_HGRANT = grant[1];

    assign HADDR  = HMASTER ? M1_HADDR  : M0_HADDR;
    assign HTRANS = HMASTER ? M1_HTRANS : M0_HTRANS;
    assign HWRITE = HMASTER ? M1_HWRITE : M0_HWRITE;
    assign HSIZE  = HMASTER ? M1_HSIZE  : M0_HSIZE;
    assign HWDATA = data_master ? M1_HWDATA : M0_HWDATA;

    assign M0_HREADY = HREADY;
    assign M1_HREADY = HREADY;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed vector table, hand-written multi-cycle corners,
// and a randomized run against a cycle-level reference model.
`timescale 1ns/1ps
module tb_ahb_master_arbiter;

    localparam int MAX_HOLD = 4;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HCLK, HRESET;
    logic        M0_HBUSREQ, M0_HLOCK, M0_HWRITE, M0_HGRANT, M0_HREADY;
    logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
    logic [1:0]  M0_HTRANS;
    logic [2:0]  M0_HSIZE;
    logic        M1_HBUSREQ, M1_HLOCK, M1_HWRITE, M1_HGRANT, M1_HREADY;
    logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
    logic [1:0]  M1_HTRANS;
    logic [2:0]  M1_HSIZE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HMASTER, HMASTLOCK;
    logic [2:0]  HSIZE;

    int checks = 0;
    int errors = 0;

    ahb_master_arbiter #(.MAX_HOLD(MAX_HOLD), .DEF_MASTER(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HBUSREQ(M0_HBUSREQ), .M0_HLOCK(M0_HLOCK), .M0_HADDR(M0_HADDR),
        .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HWDATA(M0_HWDATA), .M0_HGRANT(M0_HGRANT), .M0_HREADY(M0_HREADY),
        .M0_HRDATA(M0_HRDATA),
        .M1_HBUSREQ(M1_HBUSREQ), .M1_HLOCK(M1_HLOCK), .M1_HADDR(M1_HADDR),
        .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HWDATA(M1_HWDATA), .M1_HGRANT(M1_HGRANT), .M1_HREADY(M1_HREADY),
        .M1_HRDATA(M1_HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        HRESET = 1'b0; HREADY = 1'b1; HRDATA = 32'h0;
        M0_HBUSREQ = 1'b0; M0_HLOCK = 1'b0; M0_HTRANS = IDLE; M0_HWRITE = 1'b0;
        M0_HSIZE = 3'b010; M0_HADDR = 32'h0000_1000; M0_HWDATA = 32'h0000_00A0;
        M1_HBUSREQ = 1'b0; M1_HLOCK = 1'b0; M1_HTRANS = IDLE; M1_HWRITE = 1'b0;
        M1_HSIZE = 3'b010; M1_HADDR = 32'h4000_0010; M1_HWDATA = 32'h1111_1111;
    endtask

    task automatic do_reset();
        set_idle();
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
    endtask

    // Reference model: owner is -1 while parked, otherwise the index granted the bus.
    int m_owner, m_bus, m_dm, m_hold, m_last;
    bit m_mlock;

    task automatic model_edge();
        int tr[2];
        int rq[2];
        bit lk[2];
        int nxt;
        int gnt;
        int nreq;
        tr[0] = int'(M0_HTRANS); tr[1] = int'(M1_HTRANS);
        rq[0] = int'(M0_HBUSREQ); rq[1] = int'(M1_HBUSREQ);
        lk[0] = M0_HLOCK; lk[1] = M1_HLOCK;
        if (HRESET) begin
            m_owner = -1; m_bus = 0; m_dm = 0; m_hold = 0; m_mlock = 1'b0; m_last = 1;
            return;
        end
        if (!HREADY) return;
        gnt = (m_owner < 0) ? 0 : m_owner;
        nxt = m_owner;
        nreq = rq[0] + rq[1];
        if (tr[m_bus] != 3 && !lk[m_bus] && !m_mlock) begin
            if (m_owner >= 0 && rq[m_owner] == 1) begin
                if (rq[1 - m_owner] == 1 && m_hold >= MAX_HOLD) nxt = 1 - m_owner;
            end else if (nreq == 0) begin
                nxt = -1;
            end else if (nreq == 2) begin
                nxt = 1 - m_last;
            end else begin
                nxt = (rq[1] == 1) ? 1 : 0;
            end
        end
        if (nxt != m_owner || nxt < 0) m_hold = 0;
        else if (m_bus == m_owner && tr[m_bus] >= 2) m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        if (nxt >= 0) m_last = nxt;
        m_dm = m_bus;
        m_mlock = lk[gnt];
        m_bus = gnt;
        m_owner = nxt;
    endtask

    typedef struct {
        logic rst; logic r0; logic r1; logic [1:0] t0; logic [1:0] t1;
        logic g0; logic g1; logic hm; logic [1:0] ht;
    } vec_t;
    vec_t tbl [13];

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 1'b0, IDLE};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, NONSEQ, IDLE,   1'b1, 1'b0, 1'b0, NONSEQ};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, IDLE,   IDLE,   1'b0, 1'b1, 1'b0, IDLE};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, IDLE,   IDLE,   1'b0, 1'b1, 1'b1, IDLE};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, IDLE,   NONSEQ, 1'b0, 1'b1, 1'b1, NONSEQ};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 1'b1, IDLE};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 1'b0, IDLE};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, IDLE,   IDLE,   1'b1, 1'b0, 1'b0, IDLE};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, NONSEQ, IDLE,   1'b1, 1'b0, 1'b0, NONSEQ};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, IDLE,   IDLE,   1'b0, 1'b1, 1'b0, IDLE};
        tbl[10] = '{1'b0, 1'b0, 1'b1, IDLE,   IDLE,   1'b0, 1'b1, 1'b1, IDLE};
        tbl[11] = '{1'b0, 1'b0, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 1'b1, IDLE};
        tbl[12] = '{1'b0, 1'b0, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 1'b0, IDLE};

        set_idle();
        HRESET = 1'b1;
        #2;

        // Directed vectors: reset, parking, single request, round-robin from park.
        for (int i = 0; i < 13; i++) begin
            HRESET = tbl[i].rst;
            M0_HBUSREQ = tbl[i].r0; M1_HBUSREQ = tbl[i].r1;
            M0_HTRANS = tbl[i].t0;  M1_HTRANS = tbl[i].t1;
            cyc();
            chk($sformatf("vec%0d_m0_hgrant", i), 32'(M0_HGRANT), 32'(tbl[i].g0));
            chk($sformatf("vec%0d_m1_hgrant", i), 32'(M1_HGRANT), 32'(tbl[i].g1));
            chk($sformatf("vec%0d_hmaster", i), 32'(HMASTER), 32'(tbl[i].hm));
            chk($sformatf("vec%0d_htrans", i), 32'(HTRANS), 32'(tbl[i].ht));
        end
        chk("vec_hmastlock", 32'(HMASTLOCK), 32'd0);

        // M1 alone: grant, HMASTER lag, address mux, then write data one cycle later.
        do_reset();
        M1_HBUSREQ = 1'b1; M1_HWRITE = 1'b1; M1_HSIZE = 3'b001;
        cyc();
        chk("m1_grant_latency", 32'(M1_HGRANT), 32'd1);
        chk("m1_hmaster_lag", 32'(HMASTER), 32'd0);
        cyc();
        chk("m1_hmaster", 32'(HMASTER), 32'd1);
        M1_HTRANS = NONSEQ;
        #1;
        chk("m1_haddr", HADDR, 32'h4000_0010);
        chk("m1_hwrite", 32'(HWRITE), 32'd1);
        chk("m1_hsize", 32'(HSIZE), 32'd1);
        chk("m1_hwdata_before", HWDATA, 32'h0000_00A0);
        M1_HTRANS = IDLE;
        cyc();
        chk("m1_hwdata_after", HWDATA, 32'h1111_1111);

        // Hold-count preemption, then the same with three wait-state cycles mid-stream.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1; M0_HTRANS = NONSEQ;
            n = 0;
            while (!M1_HGRANT && n < 30) begin
                HREADY = !(run == 1 && n >= 2 && n <= 4);
                cyc();
                n++;
            end
            HREADY = 1'b1;
            chk($sformatf("hold_handover_run%0d", run), 32'(n), (run == 1) ? 32'd9 : 32'd6);
        end

        // Locked sequence blocks preemption until HMASTLOCK clears.
        do_reset();
        M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
        cyc();
        M0_HLOCK = 1'b1; M0_HTRANS = NONSEQ;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("lock%0d_m0_hgrant", k), 32'(M0_HGRANT), 32'd1);
            chk($sformatf("lock%0d_hmastlock", k), 32'(HMASTLOCK), 32'd1);
        end
        M0_HLOCK = 1'b0;
        cyc();
        chk("unlock_m0_hgrant", 32'(M0_HGRANT), 32'd1);
        chk("unlock_hmastlock", 32'(HMASTLOCK), 32'd0);
        cyc();
        chk("unlock_m1_hgrant", 32'(M1_HGRANT), 32'd1);

        // Withdrawn request mid-burst: grant holds through the SEQ beats.
        do_reset();
        M1_HBUSREQ = 1'b1;
        cyc();
        cyc();
        M0_HBUSREQ = 1'b1; M1_HTRANS = NONSEQ;
        cyc();
        chk("burst_nonseq_m1_hgrant", 32'(M1_HGRANT), 32'd1);
        M1_HBUSREQ = 1'b0; M1_HTRANS = SEQ;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("burst%0d_htrans", k), 32'(HTRANS), 32'(SEQ));
            cyc();
            chk($sformatf("burst%0d_m1_hgrant", k), 32'(M1_HGRANT), 32'd1);
        end
        M1_HTRANS = IDLE;
        cyc();
        chk("burst_end_m0_hgrant", 32'(M0_HGRANT), 32'd1);
        chk("burst_end_m1_hgrant", 32'(M1_HGRANT), 32'd0);

        // Reset overrides a stalled bus.
        cyc();
        chk("pre_reset_hmaster", 32'(HMASTER), 32'd0);
        M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b1;
        cyc();
        cyc();
        HREADY = 1'b0; HRESET = 1'b1;
        cyc();
        chk("stall_reset_m0_hgrant", 32'(M0_HGRANT), 32'd1);
        chk("stall_reset_m1_hgrant", 32'(M1_HGRANT), 32'd0);
        chk("stall_reset_hmaster", 32'(HMASTER), 32'd0);
        chk("stall_reset_hwdata", HWDATA, M0_HWDATA);
        HRESET = 1'b0; HREADY = 1'b1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            HRESET     = (c == 0) || ($urandom_range(0, 199) == 0);
            HREADY     = ($urandom_range(0, 99) < 80);
            HRDATA     = $urandom;
            M0_HBUSREQ = ($urandom_range(0, 99) < 60);
            M1_HBUSREQ = ($urandom_range(0, 99) < 60);
            M0_HLOCK   = ($urandom_range(0, 99) < 10);
            M1_HLOCK   = ($urandom_range(0, 99) < 10);
            M0_HTRANS  = 2'($urandom_range(0, 3));
            M1_HTRANS  = 2'($urandom_range(0, 3));
            M0_HWRITE  = 1'($urandom_range(0, 1));
            M1_HWRITE  = 1'($urandom_range(0, 1));
            M0_HSIZE   = 3'($urandom_range(0, 7));
            M1_HSIZE   = 3'($urandom_range(0, 7));
            M0_HADDR   = $urandom; M1_HADDR  = $urandom;
            M0_HWDATA  = $urandom; M1_HWDATA = $urandom;
            #1;
            if (c > 0) begin
                chk("rnd_haddr", HADDR, (m_bus == 1) ? M1_HADDR : M0_HADDR);
                chk("rnd_htrans", 32'(HTRANS), 32'((m_bus == 1) ? M1_HTRANS : M0_HTRANS));
                chk("rnd_hsize", 32'(HSIZE), 32'((m_bus == 1) ? M1_HSIZE : M0_HSIZE));
                chk("rnd_hwdata", HWDATA, (m_dm == 1) ? M1_HWDATA : M0_HWDATA);
                chk("rnd_m1_hrdata", M1_HRDATA, HRDATA);
            end
            @(posedge HCLK);
            model_edge();
            #1;
            chk("rnd_m0_hgrant", 32'(M0_HGRANT), 32'(m_owner != 1));
            chk("rnd_m1_hgrant", 32'(M1_HGRANT), 32'(m_owner == 1));
            chk("rnd_hmaster", 32'(HMASTER), 32'(m_bus));
            chk("rnd_hmastlock", 32'(HMASTLOCK), 32'(m_mlock));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: max address-phase transfers one owner keeps the bus while the other master requests (range 1-255).
REQ-002 SHALL have parameter DEF_MASTER, default 0: master index parked on the bus when nobody requests.
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESET  in  1  reset, synchronous and active-high.
REQ-005 Mn_HBUSREQ, n=0,1  in  1  bus request from master n.
REQ-006 Mn_HLOCK  in  1  master n requests locked (indivisible) sequence.
REQ-007 Mn_HADDR 32, Mn_HTRANS 2, Mn_HWRITE 1, Mn_HSIZE 3, Mn_HWDATA 32  in  master n address/control/write data.
REQ-008 Mn_HGRANT  out  1  bus granted to master n; exactly one grant high at all times.
REQ-009 HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32  out  muxed shared AHB-Lite bus.
REQ-010 HREADY  in  1  shared bus ready; HRDATA  in  32  shared read data; both broadcast unmodified to both masters' Mn_HREADY/Mn_HRDATA outputs.
REQ-011 HMASTER  out  1  address-phase owner index; HMASTLOCK  out  1  owner's locked sequence in progress.

Function
REQ-012 States: PARK (no requester, DEF_MASTER granted), OWN0, OWN1.
REQ-013 Arbitration point = cycle with HREADY=1 AND owner's HTRANS != SEQ AND owner's HLOCK=0.
REQ-014 At arbitration point: no requests -> PARK; one request -> that master; both -> round-robin, winner is master other than last_owner.
REQ-015 Preemption: owner keeps grant while its HBUSREQ=1 unless other master requests AND hold count >= MAX_HOLD; then grant goes to other master at next arbitration point.
REQ-016 Mn_HGRANT registered; changes only on arbitration-point edges; request-to-grant latency 1 cycle when bus idle and HREADY=1.
REQ-017 HMASTER updates to granted index on rising edge where HGRANT is already high for that master and HREADY=1 (standard AHB handover; one-cycle lag behind grant).
REQ-018 HADDR/HTRANS/HWRITE/HSIZE muxed combinationally from master HMASTER.
REQ-019 data_master register loads HMASTER on every HREADY=1 edge; HWDATA muxed from data_master, so write data follows address phase by one HREADY-qualified cycle.
REQ-020 HREADY=0 freezes HGRANT, HMASTER, data_master, hold count, state.
REQ-021 Hold counter 8-bit, cleared on ownership change or entry to PARK, +1 per HREADY=1 cycle with owner HTRANS NONSEQ/SEQ, saturates at 255.
REQ-022 HMASTLOCK = owner's HLOCK registered with HMASTER update; while high, no grant change regardless of count or requests.
REQ-023 Request withdrawn mid-SEQ burst: grant held until burst ends (HTRANS leaves SEQ).
REQ-024 last_owner updated whenever ownership moves to OWN0/OWN1.

Reset
REQ-025 HRESET=1 at edge: state PARK, Mn_HGRANT = one-hot DEF_MASTER, HMASTER=data_master=DEF_MASTER, hold count 0, HMASTLOCK 0, last_owner = 1-DEF_MASTER.
REQ-026 Reset mid-transfer overrides everything in same edge; outputs reach reset values next cycle regardless of HREADY.

Verification
REQ-027 Reset, no requests, HREADY=1 -> M0_HGRANT=1, M1_HGRANT=0, HMASTER=0, HTRANS mirrors M0_HTRANS.
REQ-028 M1 requests alone, bus idle -> M1_HGRANT=1 next cycle, HMASTER=1 cycle after, M1 write data on HWDATA one cycle after its NONSEQ.
REQ-029 Both request from PARK (last_owner=1) -> M0 granted; M0 drops HBUSREQ after one NONSEQ -> M1 granted next arbitration point.
REQ-030 MAX_HOLD=4, M0 issues continuous NONSEQ, M1 requesting -> grant moves to M1 after 4th accepted transfer; HREADY=0 for 3 cycles mid-stream delays handover 3 cycles.
REQ-031 M0 HLOCK=1 for 10 transfers with M1 requesting, MAX_HOLD=4 -> no handover until HLOCK low; HMASTLOCK=1 throughout.
REQ-032 M1 4-beat INCR burst, M1_HBUSREQ drops after NONSEQ, M0 requests -> grant stays M1 through 3 SEQ beats, moves on first non-SEQ HREADY=1 cycle.
